// File: rtl/alu_pkg.sv
// Shared definitions for the decode stage and the ALU: op codes, opcodes,
// operand-select encodings, immediate formats and the decoded bundle.
package alu_pkg;

  // ALU op codes; 4'hD..4'hF are reserved and never produced by decode
  localparam logic [3:0] ALU_PASS_B    = 4'h0;
  localparam logic [3:0] ALU_B_PLUS4   = 4'h1;
  localparam logic [3:0] ALU_ADD       = 4'h2;
  localparam logic [3:0] ALU_SUB       = 4'h3;
  localparam logic [3:0] ALU_ADD_ALIGN = 4'h4;
  localparam logic [3:0] ALU_SLL       = 4'h5;
  localparam logic [3:0] ALU_SRL       = 4'h6;
  localparam logic [3:0] ALU_SRA       = 4'h7;
  localparam logic [3:0] ALU_SLT       = 4'h8;
  localparam logic [3:0] ALU_SLTU      = 4'h9;
  localparam logic [3:0] ALU_AND       = 4'hA;
  localparam logic [3:0] ALU_OR        = 4'hB;
  localparam logic [3:0] ALU_XOR       = 4'hC;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operand selects
  localparam logic       A_SEL_RS1 = 1'b0;
  localparam logic       A_SEL_PC  = 1'b1;
  localparam logic [1:0] B_SEL_RS2 = 2'd0;
  localparam logic [1:0] B_SEL_IMM = 2'd1;
  localparam logic [1:0] B_SEL_PC  = 2'd2;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_branch;
    logic        is_jump;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

  // Shared funct3 -> op map of OP-IMM and the base-funct7 half of OP
  function automatic logic [3:0] arith_op(input logic [2:0] f3);
    case (f3)
      3'b000:  arith_op = ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Loads exist for LB, LH, LW, LBU, LHU only
  function automatic logic load_f3_ok(input logic [2:0] f3);
    load_f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the five RV32I immediate forms, all
// sign-extended from instr[31], and returns the one picked by fmt.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:7] ins,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Format select
  always_comb begin
    case (fmt)
      IMM_S:   imm = imm_s;
      IMM_B:   imm = imm_b;
      IMM_U:   imm = imm_u;
      IMM_J:   imm = imm_j;
      default: imm = imm_i;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: instruction word -> ALU op, operand
// selects, immediate and control flags, behind a valid/ready register.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            a_sel,
  output logic [1:0]      b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            is_branch,
  output logic            is_jump,
  output logic [2:0]      funct3_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic [3:0]  op_c;
  logic        asel_c;
  logic [1:0]  bsel_c;
  imm_fmt_e    fmt_c;
  logic        we_c;
  logic        mrd_c;
  logic        mwr_c;
  logic        br_c;
  logic        jmp_c;
  logic        ill_c;
  logic [31:0] imm_c;

  dec_t dec_p0;
  dec_t dec_p1;
  logic vld_p1;

  imm_gen u_imm_gen (
    .ins (instr[31:7]),
    .fmt (fmt_c),
    .imm (imm_c)
  );

  // Opcode/funct decode tables; illegal encodings squash all side effects
  always_comb begin
    op_c   = ALU_PASS_B;
    asel_c = A_SEL_RS1;
    bsel_c = B_SEL_RS2;
    fmt_c  = IMM_I;
    we_c   = 1'b0;
    mrd_c  = 1'b0;
    mwr_c  = 1'b0;
    br_c   = 1'b0;
    jmp_c  = 1'b0;
    ill_c  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op_c   = ALU_PASS_B;
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_U;
        we_c   = 1'b1;
      end
      OPC_AUIPC: begin
        op_c   = ALU_ADD;
        asel_c = A_SEL_PC;
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_U;
        we_c   = 1'b1;
      end
      OPC_JAL: begin
        op_c   = ALU_B_PLUS4;
        bsel_c = B_SEL_PC;
        fmt_c  = IMM_J;
        we_c   = 1'b1;
        jmp_c  = 1'b1;
      end
      OPC_JALR: begin
        op_c   = ALU_ADD_ALIGN;
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_I;
        we_c   = 1'b1;
        jmp_c  = 1'b1;
        ill_c  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        op_c   = ALU_SUB;
        bsel_c = B_SEL_RS2;
        fmt_c  = IMM_B;
        br_c   = 1'b1;
        ill_c  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        op_c   = ALU_ADD;
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_I;
        we_c   = 1'b1;
        mrd_c  = 1'b1;
        ill_c  = !load_f3_ok(funct3);
      end
      OPC_STORE: begin
        op_c   = ALU_ADD;
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_S;
        mwr_c  = 1'b1;
        ill_c  = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        op_c   = arith_op(funct3);
        bsel_c = B_SEL_IMM;
        fmt_c  = IMM_I;
        we_c   = 1'b1;
        if (funct3 == 3'b001) begin
          ill_c = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) op_c = ALU_SRA;
          else if (funct7 != F7_BASE) ill_c = 1'b1;
        end
      end
      OPC_OP: begin
        op_c   = arith_op(funct3);
        bsel_c = B_SEL_RS2;
        we_c   = 1'b1;
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) op_c = ALU_SUB;
          else if (funct3 == 3'b101) op_c = ALU_SRA;
          else ill_c = 1'b1;
        end else if (funct7 != F7_BASE) begin
          ill_c = 1'b1;
        end
      end
      default: ill_c = 1'b1;
    endcase
    if (ill_c) begin
      op_c  = ALU_PASS_B;
      we_c  = 1'b0;
      mrd_c = 1'b0;
      mwr_c = 1'b0;
      br_c  = 1'b0;
      jmp_c = 1'b0;
    end else if (instr[11:7] == 5'd0) begin
      we_c = 1'b0;
    end
  end

  // Assemble the decoded bundle presented to the pipeline register
  always_comb begin
    dec_p0           = '0;
    dec_p0.alu_op    = op_c;
    dec_p0.a_sel     = asel_c;
    dec_p0.b_sel     = bsel_c;
    dec_p0.imm       = imm_c;
    dec_p0.rs1       = instr[19:15];
    dec_p0.rs2       = instr[24:20];
    dec_p0.rd        = instr[11:7];
    dec_p0.reg_we    = we_c;
    dec_p0.mem_rd    = mrd_c;
    dec_p0.mem_wr    = mwr_c;
    dec_p0.is_branch = br_c;
    dec_p0.is_jump   = jmp_c;
    dec_p0.funct3    = funct3;
    dec_p0.pc        = pc;
    dec_p0.illegal   = ill_c;
  end

  assign in_ready = !vld_p1 || out_ready;

  // ---- stage boundary p0 -> p1: load on in_ready, flush kills valid ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      dec_p1 <= '0;
    end else begin
      if (flush)         vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= in_valid;
      if (in_ready)      dec_p1 <= dec_p0;
    end
  end

  assign out_valid = vld_p1;
  assign alu_op    = dec_p1.alu_op;
  assign a_sel     = dec_p1.a_sel;
  assign b_sel     = dec_p1.b_sel;
  assign imm       = dec_p1.imm;
  assign rs1       = dec_p1.rs1;
  assign rs2       = dec_p1.rs2;
  assign rd        = dec_p1.rd;
  assign reg_we    = dec_p1.reg_we;
  assign mem_rd    = dec_p1.mem_rd;
  assign mem_wr    = dec_p1.mem_wr;
  assign is_branch = dec_p1.is_branch;
  assign is_jump   = dec_p1.is_jump;
  assign funct3_o  = dec_p1.funct3;
  assign pc_o      = dec_p1.pc;
  assign illegal   = dec_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage with hand-computed expectations.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        a_sel;
  logic [1:0]  b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        is_branch;
  logic        is_jump;
  logic [2:0]  funct3_o;
  logic [31:0] pc_o;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .reg_we    (reg_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .funct3_o  (funct3_o),
    .pc_o      (pc_o),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_alu_op",    {28'd0, alu_op},    32'd0);
    chk("rst_imm",       imm,                32'd0);
    chk("rst_pc_o",      pc_o,               32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ADD x3,x1,x2
    in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h40;
    tick();
    chk("add_valid",   {31'd0, out_valid}, 32'd1);
    chk("add_op",      {28'd0, alu_op},    32'd2);
    chk("add_bsel",    {30'd0, b_sel},     32'd0);
    chk("add_rd",      {27'd0, rd},        32'd3);
    chk("add_rs1",     {27'd0, rs1},       32'd1);
    chk("add_rs2",     {27'd0, rs2},       32'd2);
    chk("add_we",      {31'd0, reg_we},    32'd1);
    chk("add_illegal", {31'd0, illegal},   32'd0);
    chk("add_pc",      pc_o,               32'h40);

    // SUB x3,x1,x2
    instr = 32'h402081B3;
    tick();
    chk("sub_op", {28'd0, alu_op}, 32'd3);
    chk("sub_we", {31'd0, reg_we}, 32'd1);

    // SRAI x5,x6,3
    instr = 32'h40335293;
    tick();
    chk("srai_op",   {28'd0, alu_op}, 32'd7);
    chk("srai_bsel", {30'd0, b_sel},  32'd1);
    chk("srai_imm",  imm,             32'h00000403);
    chk("srai_rd",   {27'd0, rd},     32'd5);

    // ADDI x1,x0,-1
    instr = 32'hFFF00093;
    tick();
    chk("addi_op",  {28'd0, alu_op}, 32'd2);
    chk("addi_imm", imm,             32'hFFFFFFFF);

    // LUI x1,0x12345
    instr = 32'h123450B7;
    tick();
    chk("lui_op",  {28'd0, alu_op}, 32'd0);
    chk("lui_imm", imm,             32'h12345000);
    chk("lui_we",  {31'd0, reg_we}, 32'd1);

    // JAL x0,+8 at pc 0x100
    instr = 32'h0080006F; pc = 32'h100;
    tick();
    chk("jal_op",   {28'd0, alu_op},  32'd1);
    chk("jal_bsel", {30'd0, b_sel},   32'd2);
    chk("jal_we",   {31'd0, reg_we},  32'd0);
    chk("jal_jump", {31'd0, is_jump}, 32'd1);
    chk("jal_imm",  imm,              32'd8);
    chk("jal_pc",   pc_o,             32'h100);

    // BEQ x1,x2,+8
    instr = 32'h00208463; pc = 32'h0;
    tick();
    chk("beq_op",  {28'd0, alu_op},    32'd3);
    chk("beq_br",  {31'd0, is_branch}, 32'd1);
    chk("beq_we",  {31'd0, reg_we},    32'd0);
    chk("beq_imm", imm,                32'd8);

    // SW x2,4(x1)
    instr = 32'h0020A223;
    tick();
    chk("sw_op",  {28'd0, alu_op}, 32'd2);
    chk("sw_wr",  {31'd0, mem_wr}, 32'd1);
    chk("sw_we",  {31'd0, reg_we}, 32'd0);
    chk("sw_imm", imm,             32'd4);

    // Branch with funct3 010
    instr = 32'h0000A063;
    tick();
    chk("ill_br_flag",  {31'd0, illegal},   32'd1);
    chk("ill_br_op",    {28'd0, alu_op},    32'd0);
    chk("ill_br_we",    {31'd0, reg_we},    32'd0);
    chk("ill_br_br",    {31'd0, is_branch}, 32'd0);
    chk("ill_br_valid", {31'd0, out_valid}, 32'd1);

    // All-ones word
    instr = 32'hFFFFFFFF;
    tick();
    chk("ill_ff_flag", {31'd0, illegal}, 32'd1);
    chk("ill_ff_op",   {28'd0, alu_op},  32'd0);
    chk("ill_ff_we",   {31'd0, reg_we},  32'd0);

    // OP funct7=0100000 funct3=111
    instr = 32'h4020F1B3;
    tick();
    chk("ill_op_flag", {31'd0, illegal}, 32'd1);
    chk("ill_op_we",   {31'd0, reg_we},  32'd0);

    // Back-pressure: ADD held while SUB waits
    instr = 32'h002081B3;
    tick();
    chk("bp_add_op", {28'd0, alu_op}, 32'd2);
    out_ready = 1'b0; instr = 32'h402081B3;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_op",    {28'd0, alu_op},    32'd2);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_rdy",   {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_sub_op",    {28'd0, alu_op},    32'd3);
    chk("bp_sub_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Flush while stalled with a new input pending
    in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    chk("fl_load", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0; instr = 32'h402081B3; flush = 1'b1;
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready},  32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // Async reset during a hold
    in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b0;
    tick();
    chk("ar_held", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_op",    {28'd0, alu_op},    32'd0);
    chk("ar_rd",    {27'd0, rd},        32'd0);
    chk("ar_we",    {31'd0, reg_we},    32'd0);
    chk("ar_ready", {31'd0, in_ready},  32'd1);
    chk("ar_pc",    pc_o,               32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage for RV32I instructions. It is the producer side of the ALU interface: it turns one instruction word into the 4-bit ALU op code, the operand selects and the immediate that the ALU and the execute stage consume.
- Sits between instruction fetch and execute.
- Uses a valid/ready handshake with stall back-pressure and flush.

Parameters:
XLEN, 32, datapath width (fixed at 32; parameter exists for documentation only)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instr/pc valid this cycle
in_ready  output  1  stage accepts input this cycle
instr  input  32  instruction word
pc  input  32  instruction address
flush  input  1  kill stage contents (branch mispredict/trap)
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts bundle
alu_op  output  4  ALU op code (encoding below)
a_sel  output  1  0=rs1, 1=pc
b_sel  output  2  0=rs2, 1=imm, 2=pc
imm  output  32  decoded immediate
rs1, rs2, rd  output  5 each  register indices
reg_we  output  1  writes rd
mem_rd, mem_wr  output  1 each  load / store
is_branch, is_jump  output  1 each  control-flow class
funct3_o  output  3  instr[14:12] passthrough (branch condition/load size)
pc_o  output  32  registered pc
illegal  output  1  undecodable instruction

Behaviour:
- ALU op encoding (shared package):
  - 0 PASS_B, 1 B_PLUS4, 2 ADD, 3 SUB, 4 ADD_ALIGN ((A+B)&~1)
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - A AND, B OR, C XOR
  - D–F reserved and never emitted.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Load enable = in_ready. On load, out_valid <= in_valid and all outputs <= the decode of instr/pc.
  - When !in_ready, all outputs hold.
- Flush: highest priority after reset. Next edge gives out_valid <= 0 regardless of in_valid/out_ready; the other outputs are don't-care. Flush together with in_valid drops that input; in_ready is unaffected by flush.
- Reset (async): out_valid, alu_op, a_sel, b_sel, imm, rs1, rs2, rd, reg_we, mem_rd, mem_wr, is_branch, is_jump, funct3_o, pc_o, illegal all 0. in_ready is then 1. Reset mid-transaction discards the held bundle.
- Latency: 1 cycle from accepted input to out_valid.
- Decode by opcode instr[6:0]:
  - LUI 0110111: PASS_B, b=imm, imm=U.
  - AUIPC 0010111: ADD, a=pc, b=imm, imm=U.
  - JAL 1101111: B_PLUS4, b=pc, imm=J, is_jump.
  - JALR 1100111 (funct3 must be 000): ADD_ALIGN, a=rs1, b=imm, imm=I, is_jump.
  - BRANCH 1100011 (funct3 010/011 illegal): SUB, b=rs2, imm=B, is_branch, reg_we=0.
  - LOAD 0000011 (funct3 in {000,001,010,100,101}): ADD, b=imm, imm=I, mem_rd.
  - STORE 0100011 (funct3 ≤ 010): ADD, b=imm, imm=S, mem_wr, reg_we=0.
  - OP-IMM 0010011: b=imm, imm=I, raw sign-extended.
    - funct3 map: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
    - 001 SLL requires funct7=0000000.
    - 101 requires funct7=0000000 (SRL) or 0100000 (SRA).
  - OP 0110011: b=rs2, funct7 ∈ {0000000, 0100000}.
    - 0100000 is legal only with funct3 000 (SUB) or 101 (SRA); otherwise the same map as OP-IMM.
- reg_we: 1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP, forced 0 when rd==0.
- Illegal instruction (any other opcode or bad funct): illegal=1; alu_op, reg_we, mem_rd, mem_wr, is_branch and is_jump all 0; out_valid follows the handshake as normal.
- Immediates are sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'h0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- rs1, rs2 and rd are always instr fields, even when unused.

Decomposition:
- Package alu_pkg:
  - ALU op localparams (shared with the ALU).
  - Opcode constants.
  - a_sel/b_sel encodings.
- One combinational sub-module, imm_gen (instr -> 5 immediate forms, selected by format).
- Decode tables and the pipeline register stay in alu_decode_stage.

Test Plan:
- ADD x3,x1,x2 = 0x002081B3, then SUB = 0x402081B3, with out_ready=1 -> next cycle out_valid=1, alu_op=2 then 3, b_sel=0, rd=3, reg_we=1, illegal=0.
- SRAI x5,x6,3 = 0x40335293 -> alu_op=7, b_sel=1, imm=0x00000403. ADDI x1,x0,-1 = 0xFFF00093 -> alu_op=2, imm=0xFFFFFFFF.
- LUI x1,0x12345 = 0x123450B7 -> alu_op=0, imm=0x12345000. JAL x0 with pc=0x100 -> alu_op=1, b_sel=2, reg_we=0 (rd==0), is_jump=1.
- Illegal: 0x0000A063 (branch funct3 010) and 0xFFFFFFFF -> illegal=1, alu_op=0, reg_we=0; an OP instruction with funct7=0100000 and funct3=111 -> illegal=1.
- Back-pressure: load ADD, hold out_ready=0 for 3 cycles while presenting SUB -> in_ready=0, outputs stay ADD. Release -> SUB appears one cycle later, no drop or duplicate.
- Flush while out_ready=0 and in_valid=1 -> out_valid=0 next edge. Assert rst asynchronously mid-hold -> all outputs 0 immediately, in_ready=1.
